modmul_controller: RTL and testbench
====================================

MODMUL_CONTROLLER -- requirements
Module: modmul_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request one modular multiplication C = A*B mod N; sampled only in IDLE.
REQ-004 SHALL have port Status_Signal, input, 3 bits from datapath:
- [0] = C >= N under the selected compare.
- [1] = current B MSB.
- [2] = iteration counter is zero.
REQ-005 SHALL have port Control_Signal, output, 15 bits to datapath, in this order:
- [14] LoadA, [13] LoadN, [12] LoadCoun, [11] LoadB, [10] ShiftB, [9] LoadC, [8] ShiftC.
- [7] S_Coun, [6] S_Comp1, [5] S_Comp2, [4] S_AS1, [3:2] S_AS2, [1] S_C, [0] AS.
REQ-006 SHALL have port busy, output, 1 bit: high from LOAD through DONE inclusive.
REQ-007 SHALL have port done, output, 1 bit: single-cycle pulse when C holds the result.

Function
REQ-008 SHALL implement FSM states IDLE, LOAD, INIT, SHIFT, RED1, ADD, RED2, DONE.
REQ-009 SHALL leave IDLE for LOAD only when start=1 is sampled at a rising edge; otherwise it SHALL stay in IDLE with Control_Signal=0.
REQ-010 SHALL in LOAD assert LoadA, LoadN and LoadB, then go to INIT.
REQ-011 SHALL in INIT assert LoadCoun with S_Coun=0 (counter := 8), and LoadC with S_C=1 (C := 0); next state SHALL be SHIFT.
REQ-012 SHALL in SHIFT assert ShiftC (C := 2C); next state SHALL be RED1.
REQ-013 SHALL in RED1 drive S_Comp1=1, S_Comp2=0; if Status[0]=1 it SHALL assert LoadC, AS=1, S_AS1=1, S_AS2=0 (C := C-N); next state SHALL be ADD.
REQ-014 SHALL in ADD assert LoadC, AS=0, S_AS1=0, S_AS2=1 (C := C+A) only when Status[1]=1; next state SHALL be RED2.
REQ-015 SHALL in RED2 apply the subtract rule of REQ-013 using S_Comp1=0, S_Comp2=1, and SHALL also assert ShiftB and LoadCoun with S_Coun=1 (decrement).
REQ-016 SHALL leave RED2 to DONE when Status[2]=1 after the decrement; otherwise it SHALL return to SHIFT.
REQ-017 SHALL in DONE assert done=1 for one cycle, hold C, and then return to IDLE.
REQ-018 SHALL decode Control_Signal combinationally from state and Status_Signal (Mealy); every bit not listed for a state SHALL be 0.
REQ-019 SHALL take exactly 35 cycles from the start-sampling edge to the done edge: LOAD 1, INIT 1, 8 iterations x 4, DONE 1.
REQ-020 SHALL ignore start while busy=1; start held high through DONE SHALL begin a new operation on the edge after DONE.

Reset
REQ-021 SHALL on rst=0, at any time including mid-operation, go to IDLE immediately; busy=0, done=0, Control_Signal=0 while reset is held.
REQ-022 SHALL after reset release require a fresh start; an aborted operation SHALL never produce done.

Configuration
REQ-023 SHALL, when MODMUL_CTRL_ABORT_EN is defined, add input abort (1 bit) and output err (1 bit).
- abort=1 in any busy state except DONE SHALL force IDLE at the next edge, with no done.
- err SHALL then be set, and cleared by the next accepted start or by reset.
REQ-024 SHALL, without MODMUL_CTRL_ABORT_EN, have no abort or err ports and no related logic.

Structure
REQ-025 SHALL take the state encoding, the Control_Signal bit indices, the Status_Signal bit indices and ITER=8 from a shared package, modmul_pkg.
REQ-026 SHALL place the state-to-control-word decode in a sub-module, modmul_ctrl_decode.

Verification
REQ-027 Bench SHALL run with the Data_Path instance and cover:
- Reset then A=15, B=25, N=148, start pulse -> done at cycle 35, C=79, busy low after DONE.
- A=97, B=15, N=113 -> C=99; ADD asserts LoadC in exactly 4 iterations (B=00001111).
- B=0, A=100, N=113 -> C=0; ADD never asserts LoadC; latency 35.
- rst=0 at cycle 20 of an operation -> Control_Signal=0 asynchronously, no done; a new start then gives the correct result.
- start held high for 80 cycles -> exactly two done pulses, with DONE->LOAD back-to-back.
- With MODMUL_CTRL_ABORT_EN: abort at cycle 10 -> IDLE next edge, err=1, no done; next start clears err.

Source files
------------

// File: rtl/modmul_pkg.sv
// Shared encodings for the modular-multiplication controller: FSM states,
// Control_Signal / Status_Signal bit positions and the iteration count.
package modmul_pkg;

  localparam int unsigned Iter  = 8;
  localparam int unsigned CtrlW = 15;
  localparam int unsigned StatW = 3;

  // Control_Signal bit positions
  localparam int unsigned CtrlLoadA    = 14;
  localparam int unsigned CtrlLoadN    = 13;
  localparam int unsigned CtrlLoadCoun = 12;
  localparam int unsigned CtrlLoadB    = 11;
  localparam int unsigned CtrlShiftB   = 10;
  localparam int unsigned CtrlLoadC    = 9;
  localparam int unsigned CtrlShiftC   = 8;
  localparam int unsigned CtrlSCoun    = 7;
  localparam int unsigned CtrlSComp1   = 6;
  localparam int unsigned CtrlSComp2   = 5;
  localparam int unsigned CtrlSAs1     = 4;
  localparam int unsigned CtrlSAs2Hi   = 3;
  localparam int unsigned CtrlSAs2Lo   = 2;
  localparam int unsigned CtrlSC       = 1;
  localparam int unsigned CtrlAs       = 0;

  // Status_Signal bit positions
  localparam int unsigned StatGe   = 0;
  localparam int unsigned StatBMsb = 1;
  localparam int unsigned StatZero = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StInit,
    StShift,
    StRed1,
    StAdd,
    StRed2,
    StDone
  } state_t;

endpackage

// File: rtl/modmul_ctrl_decode.sv
// Mealy decode of FSM state plus datapath status into the 15-bit control word.
module modmul_ctrl_decode
  import modmul_pkg::*;
(
  input  state_t           state,
  input  logic [StatW-1:0] status,
  output logic [CtrlW-1:0] ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      StLoad: begin
        ctrl[CtrlLoadA] = 1'b1;
        ctrl[CtrlLoadN] = 1'b1;
        ctrl[CtrlLoadB] = 1'b1;
      end
      StInit: begin
        // counter := Iter (S_Coun=0), C := 0 (S_C=1)
        ctrl[CtrlLoadCoun] = 1'b1;
        ctrl[CtrlLoadC]    = 1'b1;
        ctrl[CtrlSC]       = 1'b1;
      end
      StShift: ctrl[CtrlShiftC] = 1'b1;
      StRed1: begin
        ctrl[CtrlSComp1] = 1'b1;
        if (status[StatGe]) begin
          ctrl[CtrlLoadC] = 1'b1;
          ctrl[CtrlAs]    = 1'b1;
          ctrl[CtrlSAs1]  = 1'b1;
        end
      end
      StAdd: begin
        if (status[StatBMsb]) begin
          ctrl[CtrlLoadC]                 = 1'b1;
          ctrl[CtrlSAs2Hi:CtrlSAs2Lo]     = 2'b01;
        end
      end
      StRed2: begin
        ctrl[CtrlSComp2]   = 1'b1;
        ctrl[CtrlShiftB]   = 1'b1;
        ctrl[CtrlLoadCoun] = 1'b1;
        ctrl[CtrlSCoun]    = 1'b1;
        if (status[StatGe]) begin
          ctrl[CtrlLoadC] = 1'b1;
          ctrl[CtrlAs]    = 1'b1;
          ctrl[CtrlSAs1]  = 1'b1;
        end
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/modmul_controller.sv
// Sequencer for shift-and-add modular multiplication C = A*B mod N.
// Optional abort/err ports are enabled by defining MODMUL_CTRL_ABORT_EN.
module modmul_controller
  import modmul_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [StatW-1:0] Status_Signal,
  output logic [CtrlW-1:0] Control_Signal,
  output logic             busy,
  output logic             done
`ifdef MODMUL_CTRL_ABORT_EN
  ,
  input  logic             abort,
  output logic             err
`endif
);

  state_t state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MODMUL_CTRL_ABORT_EN
      err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            busy    <= 1'b1;
`ifdef MODMUL_CTRL_ABORT_EN
            err     <= 1'b0;
`endif
          end
        end
        StLoad:  state_q <= StInit;
        StInit:  state_q <= StShift;
        StShift: state_q <= StRed1;
        StRed1:  state_q <= StAdd;
        StAdd:   state_q <= StRed2;
        StRed2: begin
          if (Status_Signal[StatZero]) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else begin
            state_q <= StShift;
          end
        end
        StDone: begin
          // A held start chains straight into the next operation.
          if (start) begin
            state_q <= StLoad;
`ifdef MODMUL_CTRL_ABORT_EN
            err     <= 1'b0;
`endif
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
`ifdef MODMUL_CTRL_ABORT_EN
      if (abort && state_q != StIdle && state_q != StDone) begin
        state_q <= StIdle;
        busy    <= 1'b0;
        done    <= 1'b0;
        err     <= 1'b1;
      end
`endif
    end
  end

  modmul_ctrl_decode u_decode (
    .state  (state_q),
    .status (Status_Signal),
    .ctrl   (Control_Signal)
  );

endmodule

// File: tb/tb_modmul_controller.sv
// Directed bench for modmul_controller driving a small behavioural datapath.
module tb_modmul_controller;
  import modmul_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [StatW-1:0] status;
  logic [CtrlW-1:0] ctrl;
  logic             busy, done;
`ifdef MODMUL_CTRL_ABORT_EN
  logic             abort = 1'b0;
  logic             err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  modmul_controller dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .Status_Signal  (status),
    .Control_Signal (ctrl),
    .busy           (busy),
    .done           (done)
`ifdef MODMUL_CTRL_ABORT_EN
    ,
    .abort          (abort),
    .err            (err)
`endif
  );

  // Behavioural datapath
  logic [7:0] a_in = '0, b_in = '0, n_in = '0;
  logic [7:0] a_r, b_r, n_r;
  logic [9:0] c_r;
  logic [3:0] coun;
  int         add_cnt, done_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r <= '0; b_r <= '0; n_r <= '0; c_r <= '0; coun <= '0;
    end else begin
      if (ctrl[CtrlLoadA]) a_r <= a_in;
      if (ctrl[CtrlLoadN]) n_r <= n_in;
      if (ctrl[CtrlLoadB]) b_r <= b_in;
      else if (ctrl[CtrlShiftB]) b_r <= {b_r[6:0], 1'b0};
      if (ctrl[CtrlLoadCoun]) coun <= ctrl[CtrlSCoun] ? coun - 4'd1 : 4'(Iter);
      if (ctrl[CtrlLoadC]) begin
        if (ctrl[CtrlSC]) c_r <= '0;
        else if (ctrl[CtrlAs] && ctrl[CtrlSAs1]) c_r <= c_r - {2'b00, n_r};
        else if (ctrl[CtrlSAs2Hi:CtrlSAs2Lo] == 2'b01) c_r <= c_r + {2'b00, a_r};
      end else if (ctrl[CtrlShiftC]) begin
        c_r <= {c_r[8:0], 1'b0};
      end
    end
  end

  // Zero flag reports the count as it will be after this cycle's decrement.
  assign status = {coun == 4'd1, b_r[7], c_r >= {2'b00, n_r}};

  initial begin
    add_cnt  = 0;
    done_cnt = 0;
  end

  always @(posedge clk) begin
    if (ctrl[CtrlLoadC] && !ctrl[CtrlSC] && !ctrl[CtrlAs] &&
        ctrl[CtrlSAs2Hi:CtrlSAs2Lo] == 2'b01)
      add_cnt <= add_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Runs one operation; lat = cycles from start edge (LOAD = 1) to done, 0 on timeout.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                       output int lat, output logic [9:0] c);
    @(negedge clk);
    a_in = a; b_in = b; n_in = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    c = '0;
    for (int i = 1; i <= 100; i++) begin
      if (done) begin
        lat = i;
        c = c_r;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (ctrl !== '0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", ctrl); end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat; logic [9:0] c;
    do_op(8'd15, 8'd25, 8'd148, lat, c);
    checks++; if (lat !== 35) begin errors++; $display("FAIL basic_latency got %0d exp 35", lat); end
    checks++; if (c !== 10'd79) begin errors++; $display("FAIL basic_result got %0d exp 79", c); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
    checks++; if (ctrl !== '0) begin errors++; $display("FAIL basic_idle_ctrl got %h exp 0", ctrl); end
  endtask

  task automatic test_add_count();
    int lat, a0; logic [9:0] c;
    a0 = add_cnt;
    do_op(8'd97, 8'd15, 8'd113, lat, c);
    checks++; if (c !== 10'd99) begin errors++; $display("FAIL add_result got %0d exp 99", c); end
    checks++; if (add_cnt - a0 !== 4) begin errors++; $display("FAIL add_count got %0d exp 4", add_cnt - a0); end
    checks++; if (lat !== 35) begin errors++; $display("FAIL add_latency got %0d exp 35", lat); end
  endtask

  task automatic test_b_zero();
    int lat, a0; logic [9:0] c;
    a0 = add_cnt;
    do_op(8'd100, 8'd0, 8'd113, lat, c);
    checks++; if (c !== 10'd0) begin errors++; $display("FAIL bzero_result got %0d exp 0", c); end
    checks++; if (add_cnt - a0 !== 0) begin errors++; $display("FAIL bzero_adds got %0d exp 0", add_cnt - a0); end
    checks++; if (lat !== 35) begin errors++; $display("FAIL bzero_latency got %0d exp 35", lat); end
  endtask

  task automatic test_mid_reset();
    int lat, d0; logic [9:0] c;
    @(negedge clk);
    a_in = 8'd15; b_in = 8'd25; n_in = 8'd148;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    d0 = done_cnt;
    #2 rst = 1'b0;
    #1;
    checks++; if (ctrl !== '0) begin errors++; $display("FAIL midrst_ctrl got %h exp 0", ctrl); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got %b exp 0", busy); end
    do_op(8'd15, 8'd25, 8'd148, lat, c);
    checks++; if (c !== 10'd79) begin errors++; $display("FAIL midrst_result got %0d exp 79", c); end
  endtask

  task automatic test_back_to_back();
    int d0, dones; logic chk_next, first_seen;
    @(negedge clk);
    a_in = 8'd15; b_in = 8'd25; n_in = 8'd148;
    d0 = done_cnt;
    dones = 0; chk_next = 1'b0; first_seen = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (chk_next) begin
        chk_next = 1'b0;
        checks++;
        if (busy !== 1'b1 || ctrl[CtrlLoadA] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_reload got busy=%b loada=%b exp 1 1", busy, ctrl[CtrlLoadA]);
        end
      end
      if (done) begin
        dones++;
        if (!first_seen) begin
          first_seen = 1'b1;
          chk_next = 1'b1;
          checks++;
          if (c_r !== 10'd79) begin errors++; $display("FAIL b2b_result got %0d exp 79", c_r); end
        end
      end
    end
    start = 1'b0;
    checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", dones); end
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain got busy=%b exp 0", busy); end
  endtask

`ifdef MODMUL_CTRL_ABORT_EN
  task automatic test_abort();
    int lat, d0; logic [9:0] c;
    @(negedge clk);
    a_in = 8'd15; b_in = 8'd25; n_in = 8'd148;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL abort_err got %b exp 1", err); end
    checks++; if (ctrl !== '0) begin errors++; $display("FAIL abort_ctrl got %h exp 0", ctrl); end
    repeat (40) @(negedge clk);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", done_cnt - d0); end
    do_op(8'd97, 8'd15, 8'd113, lat, c);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err_clear got %b exp 0", err); end
    checks++; if (c !== 10'd99) begin errors++; $display("FAIL abort_result got %0d exp 99", c); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_add_count();
    test_b_zero();
    test_mid_reset();
    test_back_to_back();
`ifdef MODMUL_CTRL_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
